hwjsoc_cpu_oci_dct_accum: RTL

Direct-conditional-branch trace (DCT) accumulator for the CPU on-chip instrumentation (OCI) trace path.
- Packs one 2-bit taken/not-taken code per retired conditional branch into a 30-bit shift buffer.
- Hands completed or flushed buffers to the trace packet formatter over a valid/ready interface.
- Exposes the live dct_buffer/dct_count pair to the OCI simulation test-bench monitor.

---
 rtl/hwjsoc_cpu_oci_dct_accum_if.sv | 22 ++
 rtl/hwjsoc_cpu_oci_dct_accum.sv | 133 +++++++++++++
 2 files changed

// File: rtl/hwjsoc_cpu_oci_dct_accum_if.sv
// Packet handoff bundle between the DCT accumulator (master) and the trace
// packet formatter (slave): valid/ready plus the packed codes and their count.
interface hwjsoc_cpu_oci_dct_accum_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [29:0] pkt_buffer;
  logic [3:0]  pkt_count;

  modport master (
    output pkt_valid,
    output pkt_buffer,
    output pkt_count,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_buffer,
    input  pkt_count,
    output pkt_ready
  );
endinterface

// File: rtl/hwjsoc_cpu_oci_dct_accum.sv
// Direct-conditional-branch trace accumulator: packs 2-bit branch codes into a
// 30-bit buffer and hands packets to the formatter. Macro DCT_OVERFLOW_CNT_EN adds ovf_count.
module hwjsoc_cpu_oci_dct_accum #(
  parameter int          MAX_CODES      = 15,
  parameter logic [1:0]  CODE_TAKEN     = 2'b01,
  parameter logic [1:0]  CODE_NOT_TAKEN = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
`ifdef DCT_OVERFLOW_CNT_EN
  output logic [7:0]  ovf_count,
`endif
  hwjsoc_cpu_oci_dct_accum_if.master pkt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CODES);

  logic [29:0] r_buffer;
  logic [3:0]  r_count;
  logic        r_flush_pending;
  logic        r_pkt_valid;
  logic [29:0] r_pkt_buffer;
  logic [3:0]  r_pkt_count;
  logic        r_overflow;

  logic        w_branch;
  logic        w_accept;
  logic        w_drop;
  logic [1:0]  w_code;
  logic [29:0] w_buf_acc;
  logic [3:0]  w_cnt_acc;
  logic        w_pkt_free;
  logic        w_pop;
  logic        w_want_xfer;
  logic        w_xfer;

  assign w_branch = br_valid & trace_enable;
  // The count only rests at MAX_CODES while a full transfer is blocked, so
  // every enabled branch seen then has nowhere to go.
  assign w_accept = w_branch & (r_count < MAX_CNT);
  assign w_drop   = w_branch & ~(r_count < MAX_CNT);
  assign w_code   = br_taken ? CODE_TAKEN : CODE_NOT_TAKEN;

  // Accumulator view including this cycle's accept, so a transfer on the
  // same edge carries the newest code with it.
  assign w_buf_acc = w_accept ? {r_buffer[27:0], w_code} : r_buffer;
  assign w_cnt_acc = r_count + {3'b000, w_accept};

  assign w_pkt_free  = ~r_pkt_valid | pkt.pkt_ready;
  assign w_pop       = r_pkt_valid & pkt.pkt_ready;
  assign w_want_xfer = (w_cnt_acc == MAX_CNT) |
                       ((flush | r_flush_pending) & (w_cnt_acc != 4'd0));
  assign w_xfer      = w_want_xfer & w_pkt_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buffer        <= '0;
      r_count         <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_buffer <= '0;
        r_count  <= '0;
      end else begin
        r_buffer <= w_buf_acc;
        r_count  <= w_cnt_acc;
      end

      if (w_xfer) begin
        r_flush_pending <= 1'b0;
      end else if (flush & (w_cnt_acc != 4'd0)) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  // Packet register: a pop and a reload on the same edge keep valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_valid  <= 1'b0;
      r_pkt_buffer <= '0;
      r_pkt_count  <= '0;
    end else if (w_xfer) begin
      r_pkt_valid  <= 1'b1;
      r_pkt_buffer <= w_buf_acc;
      r_pkt_count  <= w_cnt_acc;
    end else if (w_pop) begin
      r_pkt_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef DCT_OVERFLOW_CNT_EN
  logic [7:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_count <= '0;
    end else if (ovf_clr) begin
      r_ovf_count <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

  assign dct_buffer     = r_buffer;
  assign dct_count      = r_count;
  assign overflow       = r_overflow;
  assign pkt.pkt_valid  = r_pkt_valid;
  assign pkt.pkt_buffer = r_pkt_buffer;
  assign pkt.pkt_count  = r_pkt_count;

endmodule
